// File: rtl/word_matcher.sv
// Letter-by-letter matcher for the typing game: commits released keys against the target
// word, counts completed words and errors, ends the game at WORD_LIMIT. Option: ERROR_RESTART_EN.
module word_matcher #(
   parameter int unsigned LETTERS    = 4,
   parameter int unsigned CODE_W     = 5,
   parameter int unsigned WORD_LIMIT = 50,
   parameter int unsigned BKSP_CODE  = 27
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [CODE_W-1:0]           keystroke,
   input  logic                        keyReleased,
   input  logic [LETTERS*CODE_W-1:0]   currentWord,
   output logic [2:0]                  charIndex,
   output logic                        wordComplete,
   output logic [10:0]                 totalWords,
   output logic [7:0]                  errorCount,
   output logic                        gameOver,
   output logic [1:0]                  state
);
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned TOTAL_W = 11;
   localparam int unsigned ERR_W   = 8;
   localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;
   localparam logic [ERR_W-1:0]   ERR_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'b00,
      S_TYPING    = 2'b01,
      S_WORD_DONE = 2'b10,
      S_OVER      = 2'b11
   } state_t;

   state_t               state_q, state_d;
   logic                 rel_q;
   logic [CODE_W-1:0]    code_q;
   logic [IDX_W-1:0]     idx_d;
   logic                 done_d;
   logic [TOTAL_W-1:0]   total_d;
   logic [ERR_W-1:0]     err_d;
   logic                 over_d;
   logic                 commit;
   logic [CODE_W-1:0]    commit_code;
   logic [IDX_W-1:0]     word_len;
   logic [CODE_W-1:0]    expected;

   // Key commits on the release rising edge; fall back to last cycle's code if already cleared
   assign commit      = keyReleased & ~rel_q;
   assign commit_code = (keystroke != '0) ? keystroke : code_q;
   assign state       = state_q;

   // Number of leading nonzero letters; letter 0 sits in the top slice
   always_comb begin
      word_len = '0;
      for (int i = 0; i < int'(LETTERS); i++) begin
         if (currentWord[(int'(LETTERS) - 1 - i)*int'(CODE_W) +: CODE_W] != '0 &&
             word_len == IDX_W'(i))
            word_len = IDX_W'(i + 1);
      end
   end

   // Letter expected at the current index; zero past the end of the word
   always_comb begin
      expected = '0;
      for (int i = 0; i < int'(LETTERS); i++) begin
         if (charIndex == IDX_W'(i))
            expected = currentWord[(int'(LETTERS) - 1 - i)*int'(CODE_W) +: CODE_W];
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = charIndex;
      done_d  = 1'b0;
      total_d = totalWords;
      err_d   = errorCount;
      over_d  = gameOver;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_TYPING;
         end
         S_TYPING: begin
            if (start && commit && word_len != '0 && commit_code != '0) begin
               if (commit_code == CODE_W'(BKSP_CODE)) begin
                  if (charIndex != '0) idx_d = charIndex - 1'b1;
               end else if (commit_code == expected) begin
                  idx_d = charIndex + 1'b1;
                  if (idx_d == word_len) begin
                     state_d = S_WORD_DONE;
                     done_d  = 1'b1;
                     if (totalWords != TOTAL_MAX) total_d = totalWords + 1'b1;
                  end
               end else begin
                  if (errorCount != ERR_MAX) err_d = errorCount + 1'b1;
`ifdef ERROR_RESTART_EN
                  idx_d = '0;
`endif
               end
            end
         end
         S_WORD_DONE: begin
            idx_d = '0;
            if (32'(totalWords) == WORD_LIMIT) begin
               state_d = S_OVER;
               over_d  = 1'b1;
            end else begin
               state_d = S_TYPING;
            end
         end
         S_OVER: begin
            over_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rel_q        <= 1'b1;
         code_q       <= '0;
         charIndex    <= '0;
         wordComplete <= 1'b0;
         totalWords   <= '0;
         errorCount   <= '0;
         gameOver     <= 1'b0;
      end else begin
         state_q      <= state_d;
         rel_q        <= keyReleased;
         code_q       <= keystroke;
         charIndex    <= idx_d;
         wordComplete <= done_d;
         totalWords   <= total_d;
         errorCount   <= err_d;
         gameOver     <= over_d;
      end
   end
endmodule

// File: tb/tb_word_matcher.sv
// Randomized + directed bench for word_matcher: three instances (limits 50, 2, 4000) on shared
// inputs, each compared every cycle against a behavioural model of the game rules.
module tb_word_matcher;
   localparam int NI   = 3;
   localparam int BKSP = 27;

   logic        clk, reset, start, keyReleased;
   logic [4:0]  keystroke;
   logic [19:0] currentWord;

   logic [2:0]  ci [NI];
   logic        wc [NI];
   logic [10:0] tw [NI];
   logic [7:0]  ec [NI];
   logic        go [NI];
   logic [1:0]  st [NI];

   int limits [NI] = '{50, 2, 4000};
   int m_st [NI], m_idx [NI], m_tot [NI], m_err [NI], m_over [NI], m_wc [NI];
   int m_rel_prev, m_code_prev;
   int n_checks, n_pass;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      word_matcher #(.WORD_LIMIT(g == 0 ? 50 : (g == 1 ? 2 : 4000))) u_dut (
         .clk(clk), .reset(reset), .start(start), .keystroke(keystroke),
         .keyReleased(keyReleased), .currentWord(currentWord),
         .charIndex(ci[g]), .wordComplete(wc[g]), .totalWords(tw[g]),
         .errorCount(ec[g]), .gameOver(go[g]), .state(st[g]));
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
   endtask

   function automatic int letter_at(input logic [19:0] w, input int k);
      if (k < 0 || k > 3) return 0;
      return int'((w >> (5*(3-k))) & 20'h1f);
   endfunction

   function automatic logic [19:0] mk_word(input int a, input int b, input int c, input int d);
      return {5'(a), 5'(b), 5'(c), 5'(d)};
   endfunction

   // Game rules applied to the inputs present just before the coming edge
   task automatic model_eval();
      bit cm;
      int code, wlen;
      cm   = keyReleased && (m_rel_prev == 0);
      code = (keystroke != 0) ? int'(keystroke) : m_code_prev;
      wlen = 0;
      while (wlen < 4 && letter_at(currentWord, wlen) != 0) wlen++;
      for (int i = 0; i < NI; i++) begin
         m_wc[i] = 0;
         if (reset) begin
            m_st[i] = 0; m_idx[i] = 0; m_tot[i] = 0; m_err[i] = 0; m_over[i] = 0;
         end else begin
            case (m_st[i])
               0: if (start) m_st[i] = 1;
               1: if (start && cm && wlen > 0 && code != 0) begin
                     if (code == BKSP) begin
                        if (m_idx[i] > 0) m_idx[i]--;
                     end else if (code == letter_at(currentWord, m_idx[i])) begin
                        m_idx[i]++;
                        if (m_idx[i] == wlen) begin
                           m_st[i] = 2; m_wc[i] = 1;
                           if (m_tot[i] < 2047) m_tot[i]++;
                        end
                     end else begin
                        if (m_err[i] < 255) m_err[i]++;
`ifdef ERROR_RESTART_EN
                        m_idx[i] = 0;
`endif
                     end
                  end
               2: begin
                     m_idx[i] = 0;
                     if (m_tot[i] == limits[i]) begin m_st[i] = 3; m_over[i] = 1; end
                     else m_st[i] = 1;
                  end
               default: ;
            endcase
         end
      end
      if (reset) begin m_rel_prev = 1; m_code_prev = 0; end
      else begin m_rel_prev = int'(keyReleased); m_code_prev = int'(keystroke); end
   endtask

   task automatic compare_all();
      for (int i = 0; i < NI; i++) begin
         check($sformatf("charIndex[%0d]", i), int'(ci[i]), m_idx[i]);
         check($sformatf("wordComplete[%0d]", i), int'(wc[i]), m_wc[i]);
         check($sformatf("totalWords[%0d]", i), int'(tw[i]), m_tot[i]);
         check($sformatf("errorCount[%0d]", i), int'(ec[i]), m_err[i]);
         check($sformatf("gameOver[%0d]", i), int'(go[i]), m_over[i]);
         check($sformatf("state[%0d]", i), int'(st[i]), m_st[i]);
      end
   endtask

   task automatic step();
      model_eval();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   // One key press: held low one cycle, then released (optionally with the code already gone)
   task automatic press(input int code, input bit drop);
      keystroke   = 5'(code);
      keyReleased = 1'b0;
      step();
      if (drop) keystroke = 5'd0;
      keyReleased = 1'b1;
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int r, len;
      int lt [4];
      n_checks = 0; n_pass = 0;
      reset = 1'b1; start = 1'b0; keyReleased = 1'b1; keystroke = '0;
      currentWord = mk_word(3, 1, 20, 0);
      do_reset();
      check("reset_state", int'(st[0]), 0);
      check("reset_total", int'(tw[0]), 0);

      // CAT typed cleanly, last key committed with the code already released
      start = 1'b1;
      step();
      press(3, 0);
      check("cat_idx1", int'(ci[0]), 1);
      press(1, 0);
      check("cat_idx2", int'(ci[0]), 2);
      press(20, 1);
      check("cat_wc", int'(wc[0]), 1);
      check("cat_total", int'(tw[0]), 1);
      step();
      check("cat_wc_drop", int'(wc[0]), 0);
      check("cat_idx0", int'(ci[0]), 0);

      // Mismatch then backspace
      press(3, 0);
      press(5, 0);
      check("mis_err", int'(ec[0]), 1);
`ifdef ERROR_RESTART_EN
      check("mis_idx", int'(ci[0]), 0);
`else
      check("mis_idx", int'(ci[0]), 1);
`endif
      press(BKSP, 0);
      check("bksp_idx", int'(ci[0]), 0);

      // Long release: exactly one commit
      keystroke = 5'd3; keyReleased = 1'b0;
      step();
      keyReleased = 1'b1;
      repeat (10) step();
      check("hold_idx", int'(ci[0]), 1);

      // Paused game ignores commits
      start = 1'b0;
      press(1, 0);
      check("pause_idx", int'(ci[0]), 1);
      start = 1'b1;

      // Second word ends the limit-2 instance
      press(1, 0);
      press(20, 0);
      step();
      check("l2_over", int'(go[1]), 1);
      check("l2_state", int'(st[1]), 3);
      press(3, 0);
      check("l2_total", int'(tw[1]), 2);

      // Reset mid-word with index 2 and four errors
      do_reset();
      step();
      repeat (4) press(9, 0);
      press(3, 0);
      press(1, 0);
      check("pre_rst_idx", int'(ci[0]), 2);
      check("pre_rst_err", int'(ec[0]), 4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_idx", int'(ci[0]), 0);
      check("rst_err", int'(ec[0]), 0);
      check("rst_state", int'(st[0]), 0);

      // Randomized play with occasional word changes and pauses
      for (int n = 0; n < 1200; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            len = $urandom_range(0, 4);
            for (int k = 0; k < 4; k++) lt[k] = (k < len) ? $urandom_range(1, 4) : 0;
            currentWord = mk_word(lt[0], lt[1], lt[2], lt[3]);
         end
         start = ($urandom_range(0, 15) != 0);
         r = $urandom_range(0, 9);
         if (r < 5)       keystroke = 5'(letter_at(currentWord, m_idx[0]));
         else if (r == 5) keystroke = 5'(BKSP);
         else if (r == 6) keystroke = 5'd0;
         else             keystroke = 5'($urandom_range(1, 26));
         keyReleased = 1'($urandom_range(0, 1));
         step();
      end

      // Error counter saturation
      do_reset();
      start = 1'b1;
      currentWord = mk_word(3, 1, 20, 0);
      step();
      repeat (260) press(9, 0);
      check("err_sat", int'(ec[0]), 255);

      // Word counter saturation on the 4000-limit instance
      currentWord = mk_word(1, 0, 0, 0);
      repeat (2060) press(1, 0);
      step();
      check("tot_sat", int'(tw[2]), 2047);
      check("tot_limit50", int'(tw[0]), 50);
      check("over50", int'(go[0]), 1);
      check("big_not_over", int'(go[2]), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
